id_issue_stage: RTL
===================

Name: id_issue_stage

Overview:
Instruction-decode stage that produces every field captured by the ID/EX pipeline register.
- Decodes the IF/ID instruction word.
- Reads a 16x32 register file with write-back bypass.
- Detects load-use hazards against the instruction currently in EX.
- Inserts bubbles on stall or flush, and keeps sticky illegal-opcode and saturating stall-count status.

Parameters:
DW, 32, datapath / register width
NREG, 16, register count (register-number width AW = 4)
CNT_W, 32, stall counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
pc_in  in  32  PC of instruction in IF/ID
instr  in  32  instruction word from IF/ID
if_valid  in  1  IF/ID holds a real instruction
ex_mr  in  1  MR of instruction now in ID/EX
ex_wn  in  4  WN of instruction now in ID/EX
flush  in  1  discard current ID instruction (taken branch)
wb_en  in  1  write-back enable
wb_wn  in  4  write-back register number
wb_data  in  32  write-back data
pc_out  out  32  to ID/EX pc
RD1  out  32  rs1 read data
RD2  out  32  rs2 read data
Imm  out  32  sign-extended immediate
RN1  out  4  rs1 number
RN2  out  4  rs2 number
WN  out  4  destination number
ALUOp  out  2  00 add, 01 sub, 10 R-type funct
ALUSrc  out  1  1 selects Imm as ALU operand B
MR  out  1  memory read
MW  out  1  memory write
MReg  out  1  write-back selects memory data
EnRW  out  1  register write enable
stall  out  1  hold PC and IF/ID this cycle
illegal_seen  out  1  sticky illegal-opcode flag
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset is synchronous, active-high, on clock clk.
- Instruction format:
  - [31:28] opcode, [27:24] rd, [23:20] rs1, [19:16] rs2.
  - [15:0] imm16; Imm = sign-extended imm16.
  - R-type funct is imm[2:0] and is consumed in EX.
- Decode. Signals not listed are 0. Unlisted opcodes are illegal and decode as NOP.
  - 0x0 NOP: all control signals 0.
  - 0x1 RTYPE: ALUOp=10, EnRW=1, WN=rd.
  - 0x2 ADDI: ALUOp=00, ALUSrc=1, EnRW=1, WN=rd.
  - 0x3 LW: ALUOp=00, ALUSrc=1, MR=1, MReg=1, EnRW=1, WN=rd.
  - 0x4 SW: ALUOp=00, ALUSrc=1, MW=1.
  - 0x5 BEQ: ALUOp=01.
- Source-use flags:
  - rs1 is used by opcodes 0x1 to 0x5.
  - rs2 is used by RTYPE, SW and BEQ.
- Register file:
  - 16 x DW storage; register r0 reads 0 and writes to it are ignored.
  - Write at posedge when wb_en && wb_wn != 0.
  - Reads are combinational (zero latency).
  - Bypass: if wb_en && wb_wn == rn && rn != 0, the read returns wb_data in the same cycle.
- Hazard: load_use = if_valid && ex_mr && ex_wn != 0 && ((rs1 used && ex_wn == rs1) || (rs2 used && ex_wn == rs2)).
  - stall = load_use && !flush, so flush wins when both occur.
  - A stall lasts exactly one cycle per load. The next cycle the load has moved on, so ex_mr drops unless it is back-to-back.
- Bubble condition: reset || !if_valid || flush || stall.
  - Forces ALUOp, ALUSrc, MR, MW, MReg and EnRW to 0.
  - pc_out, RD1, RD2, Imm, RN1, RN2 and WN pass through unchanged.
- illegal_seen:
  - Set at posedge when if_valid && !flush && !stall && the opcode is illegal.
  - Cleared only by reset.
- stall_count:
  - Increments at posedge while stall = 1.
  - Saturates at 2^CNT_W - 1; it does not wrap.
- Reset values:
  - All registers = 0, illegal_seen = 0, stall_count = 0.
  - While reset is high: stall = 0 and all control outputs = 0.
  - A write-back pending while reset is high is dropped.
  - Reset mid-stall ends the stall and leaves no residual state.

Decomposition:
- Shared package id_pkg holds:
  - opcode constants: OP_NOP, OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ;
  - ALUOp encodings: ALU_ADD, ALU_SUB, ALU_RT;
  - instruction field bit positions;
  - a control-bundle struct typedef.
- Sub-module regfile_2r1w: 16x32 storage, r0 reads zero, write-through bypass. The decode, hazard and status logic stays in id_issue_stage.

Test Plan:
- Reset, then instr=0x2120_0005 (ADDI r1, r2, 5) with r2 preloaded to 7 via the wb port.
  - Expect Imm=5, RD1=7, WN=1, ALUSrc=1, EnRW=1, ALUOp=00, stall=0.
- Apply wb_en=1, wb_wn=3, wb_data=0xDEADBEEF in the same cycle as RTYPE with rs1=3.
  - Expect RD1=0xDEADBEEF (bypass).
  - Then wb_wn=0, wb_data=5: a read of r0 returns 0.
- Load-use: ex_mr=1, ex_wn=4, instr RTYPE with rs2=4.
  - Expect stall=1, all controls 0, stall_count goes 0 to 1.
  - Next cycle ex_mr=0: stall=0 and normal decode.
- Same hazard with flush=1.
  - Expect stall=0, bubble, stall_count unchanged.
  - SW whose rs2 matches ex_wn stalls; ADDI whose rs2 field matches ex_wn does not.
- Illegal opcode 0xF with if_valid=1: controls 0 and illegal_seen=1 next cycle.
  - illegal_seen persists across later valid instructions; reset clears it.
- Force 2^CNT_W + 3 stall cycles (CNT_W=4 build): stall_count saturates at 15.
  - Reset asserted mid-stall: stall_count=0, stall=0 on the next edge.

Source files
------------

// File: rtl/id_pkg.sv
// Shared definitions for the instruction-decode stage: opcodes, ALU
// operation encodings, instruction field positions and the control bundle.
package id_pkg;

  // Instruction field bit positions
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 28;
  localparam int RD_HI  = 27;
  localparam int RD_LO  = 24;
  localparam int RS1_HI = 23;
  localparam int RS1_LO = 20;
  localparam int RS2_HI = 19;
  localparam int RS2_LO = 16;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_RTYPE = 4'h1,
    OP_ADDI  = 4'h2,
    OP_LW    = 4'h3,
    OP_SW    = 4'h4,
    OP_BEQ   = 4'h5
  } opcode_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_RT  = 2'b10
  } alu_op_e;

  // Control fields carried into ID/EX; all-zero is a bubble
  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    mr;
    logic    mw;
    logic    mreg;
    logic    en_rw;
  } ctrl_t;

endpackage

// File: rtl/id_issue_stage_if.sv
// Bus between the IF/ID side (plus hazard/write-back inputs) and the
// decode stage outputs feeding the ID/EX register.
interface id_issue_stage_if #(
  parameter int DW    = 32,
  parameter int AW    = 4,
  parameter int CNT_W = 32
);
  logic [31:0]    pc_in;
  logic [31:0]    instr;
  logic           if_valid;
  logic           ex_mr;
  logic [AW-1:0]  ex_wn;
  logic           flush;
  logic           wb_en;
  logic [AW-1:0]  wb_wn;
  logic [DW-1:0]  wb_data;

  logic [31:0]    pc_out;
  logic [DW-1:0]  RD1;
  logic [DW-1:0]  RD2;
  logic [DW-1:0]  Imm;
  logic [AW-1:0]  RN1;
  logic [AW-1:0]  RN2;
  logic [AW-1:0]  WN;
  logic [1:0]     ALUOp;
  logic           ALUSrc;
  logic           MR;
  logic           MW;
  logic           MReg;
  logic           EnRW;
  logic           stall;
  logic           illegal_seen;
  logic [CNT_W-1:0] stall_count;

  // Driver of instructions / pipeline context
  modport master (
    output pc_in, instr, if_valid, ex_mr, ex_wn, flush, wb_en, wb_wn, wb_data,
    input  pc_out, RD1, RD2, Imm, RN1, RN2, WN, ALUOp, ALUSrc, MR, MW, MReg,
           EnRW, stall, illegal_seen, stall_count
  );

  // Decode stage
  modport slave (
    input  pc_in, instr, if_valid, ex_mr, ex_wn, flush, wb_en, wb_wn, wb_data,
    output pc_out, RD1, RD2, Imm, RN1, RN2, WN, ALUOp, ALUSrc, MR, MW, MReg,
           EnRW, stall, illegal_seen, stall_count
  );
endinterface

// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file; r0 is hardwired to zero and reads
// see a same-cycle write-back (write-through bypass).
module regfile_2r1w #(
  parameter int DW   = 32,
  parameter int NREG = 16,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] wa_i,
  input  logic [DW-1:0] wd_i,
  input  logic [AW-1:0] ra1_i,
  input  logic [AW-1:0] ra2_i,
  output logic [DW-1:0] rd1_o,
  output logic [DW-1:0] rd2_o
);

  logic [DW-1:0] mem_q [NREG];

  // Storage update: clear everything on reset, otherwise accept non-r0 writes
  always_ff @(posedge clk) begin
    // NOTE: the whole array is reset because architectural register state
    // must be zero after reset; this forces flops rather than a RAM macro.
    if (reset) begin
      mem_q <= '{default: '0};
    end else if (we_i && (wa_i != '0)) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  // Combinational reads with r0 forced to zero and write-back bypass
  always_comb begin
    rd1_o = mem_q[ra1_i];
    rd2_o = mem_q[ra2_i];
    if (we_i && (wa_i == ra1_i)) rd1_o = wd_i;
    if (we_i && (wa_i == ra2_i)) rd2_o = wd_i;
    if (ra1_i == '0) rd1_o = '0;
    if (ra2_i == '0) rd2_o = '0;
  end

endmodule

// File: rtl/id_issue_stage.sv
// Instruction-decode stage: decodes IF/ID, reads operands, detects
// load-use hazards, inserts bubbles and tracks illegal/stall status.
module id_issue_stage
  import id_pkg::*;
#(
  parameter int DW    = 32,
  parameter int NREG  = 16,
  parameter int CNT_W = 32
) (
  input logic         clk,
  input logic         reset,
  id_issue_stage_if.slave bus
);

  localparam int AW = $clog2(NREG);

  logic [3:0]    opcode;
  logic [AW-1:0] rd, rs1, rs2;
  ctrl_t         dec_ctrl;
  logic [AW-1:0] wn_dec;
  logic          use_rs1, use_rs2, illegal;
  logic          load_use, stall, bubble;

  logic             illegal_seen_q;
  logic [CNT_W-1:0] stall_count_q;

  assign opcode = bus.instr[OPC_HI:OPC_LO];
  assign rd     = bus.instr[RD_HI:RD_LO];
  assign rs1    = bus.instr[RS1_HI:RS1_LO];
  assign rs2    = bus.instr[RS2_HI:RS2_LO];

  // Opcode decode into control bundle, destination and source-use flags
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    dec_ctrl = '0;
    wn_dec   = '0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_NOP: ;
      OP_RTYPE: begin
        dec_ctrl.alu_op = ALU_RT;
        dec_ctrl.en_rw  = 1'b1;
        wn_dec  = rd;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_ADDI: begin
        dec_ctrl.alu_src = 1'b1;
        dec_ctrl.en_rw   = 1'b1;
        wn_dec  = rd;
        use_rs1 = 1'b1;
      end
      OP_LW: begin
        dec_ctrl.alu_src = 1'b1;
        dec_ctrl.mr      = 1'b1;
        dec_ctrl.mreg    = 1'b1;
        dec_ctrl.en_rw   = 1'b1;
        wn_dec  = rd;
        use_rs1 = 1'b1;
      end
      OP_SW: begin
        dec_ctrl.alu_src = 1'b1;
        dec_ctrl.mw      = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_BEQ: begin
        dec_ctrl.alu_op = ALU_SUB;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  // A load in EX whose destination feeds this instruction must hold one cycle;
  // a taken-branch flush discards the instruction so it never stalls.
  assign load_use = bus.if_valid && bus.ex_mr && (bus.ex_wn != '0) &&
                    ((use_rs1 && (bus.ex_wn == rs1)) ||
                     (use_rs2 && (bus.ex_wn == rs2)));
  assign stall  = load_use && !bus.flush && !reset;
  assign bubble = reset || !bus.if_valid || bus.flush || stall;

  regfile_2r1w #(.DW(DW), .NREG(NREG), .AW(AW)) u_rf (
    .clk   (clk),
    .reset (reset),
    .we_i  (bus.wb_en),
    .wa_i  (bus.wb_wn),
    .wd_i  (bus.wb_data),
    .ra1_i (rs1),
    .ra2_i (rs2),
    .rd1_o (bus.RD1),
    .rd2_o (bus.RD2)
  );

  // Status: sticky illegal flag and saturating stall counter
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      illegal_seen_q <= 1'b0;
      stall_count_q  <= '0;
    end else begin
      if (bus.if_valid && !bus.flush && !stall && illegal)
        illegal_seen_q <= 1'b1;
      if (stall && (stall_count_q != {CNT_W{1'b1}}))
        stall_count_q <= stall_count_q + CNT_W'(1);
    end
  end

  assign bus.pc_out       = bus.pc_in;
  assign bus.Imm          = {{(DW-16){bus.instr[IMM_HI]}}, bus.instr[IMM_HI:IMM_LO]};
  assign bus.RN1          = rs1;
  assign bus.RN2          = rs2;
  assign bus.WN           = wn_dec;
  assign bus.ALUOp        = bubble ? ALU_ADD : dec_ctrl.alu_op;
  assign bus.ALUSrc       = !bubble && dec_ctrl.alu_src;
  assign bus.MR           = !bubble && dec_ctrl.mr;
  assign bus.MW           = !bubble && dec_ctrl.mw;
  assign bus.MReg         = !bubble && dec_ctrl.mreg;
  assign bus.EnRW         = !bubble && dec_ctrl.en_rw;
  assign bus.stall        = stall;
  assign bus.illegal_seen = illegal_seen_q;
  assign bus.stall_count  = stall_count_q;

endmodule
